// File: rtl/threshold_arb_pkg.sv
// Shared types and width helpers for the threshold calculator arbiter.
package threshold_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // Width of the WAIT-phase timeout counter.
  function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
    return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
  endfunction

endpackage

// File: rtl/threshold_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first eligible index at or after rr_ptr.
module rr_pick
  import threshold_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_valid
);

  // Scan NUM_REQ positions starting at rr_ptr, keep the first hit.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any_valid && eligible[idx[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        gnt_idx   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/threshold_arbiter.sv
// Round-robin sequencer sharing one threshold calculator among NUM_REQ engines.
module threshold_arbiter
  import threshold_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned REF_LEN_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic                              calc_start,
  output logic [idx_width(NUM_REQ)-1:0]     calc_sel,
  input  logic                              calc_done,
  input  logic [REF_LEN_WIDTH-1:0]          calc_threshold,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [NUM_REQ*REF_LEN_WIDTH-1:0]  rsp_threshold,
  output logic [NUM_REQ-1:0]                rsp_err,
  output logic                              busy,
  output logic                              err_timeout,
  output logic                              err_spurious
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

  arb_state_e                             state_q, state_d;
  logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                       sel_q, sel_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   start_q, start_d;
  logic [NUM_REQ-1:0]                     ack_q, ack_d;
  logic [NUM_REQ-1:0]                     rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]                     rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0][REF_LEN_WIDTH-1:0]  rsp_thr_q, rsp_thr_d;
  logic                                   busy_q, busy_d;
  logic                                   err_to_q, err_to_d;
  logic                                   err_sp_q, err_sp_d;

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // A full response slot masks its requester until consumed.
  assign eligible = req_valid & ~rsp_valid_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .gnt_idx   (pick_idx),
    .any_valid (pick_any)
  );

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    ack_d       = '0;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_err_d   = rsp_err_q;
    rsp_thr_d   = rsp_thr_q;
    err_to_d    = err_to_q;
    err_sp_d    = err_sp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (calc_done) err_sp_d = 1'b1;
        if (pick_any) begin
          state_d         = ST_ISSUE;
          start_d         = 1'b1;
          ack_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          cnt_d           = '0;
          rr_ptr_d        = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        if (calc_done) err_sp_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (calc_done) begin
          rsp_thr_d[sel_q]   = calc_threshold;
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d[sel_q]   = 1'b0;
          state_d            = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_thr_d[sel_q]   = '0;
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d[sel_q]   = 1'b1;
          err_to_d           = 1'b1;
          state_d            = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_thr_q   <= '0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_sp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_thr_q   <= rsp_thr_d;
      busy_q      <= busy_d;
      err_to_q    <= err_to_d;
      err_sp_q    <= err_sp_d;
    end
  end

  assign req_ack       = ack_q;
  assign calc_start    = start_q;
  assign calc_sel      = sel_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_threshold = rsp_thr_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = busy_q;
  assign err_timeout   = err_to_q;
  assign err_spurious  = err_sp_q;

endmodule

// File: doc/threshold_arbiter.md
# threshold_arbiter

Round-robin arbiter and sequencer that shares one wavefront threshold calculator among NUM_REQ wavefront engines. It grants one requester at a time and drives the calculator's start pulse and the operand-mux select. It captures the returned threshold into a per-requester response slot and guards the transaction with a completion timeout. It sits between the wavefront engines and the single threshold calculator instance in the WFA-adaptive tile pipeline.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting wavefront engines (≥2).
- REF_LEN_WIDTH, 8: threshold width.
- TIMEOUT_CYC, 64: maximum WAIT cycles before abort (≥2).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NUM_REQ  per-requester request level; held until req_ack.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse; request consumed.
- calc_start  out  1  one-cycle start pulse to the calculator.
- calc_sel  out  $clog2(NUM_REQ)  granted index; steers external operand mux (offsets, valid mask, lengths).
- calc_done  in  1  one-cycle completion pulse from the calculator.
- calc_threshold  in  REF_LEN_WIDTH  result, valid with calc_done.
- rsp_valid  out  NUM_REQ  per-requester result slot full.
- rsp_ready  in  NUM_REQ  per-requester consume; clears slot.
- rsp_threshold  out  NUM_REQ×REF_LEN_WIDTH  per-slot result.
- rsp_err  out  NUM_REQ  per-slot: result produced by timeout abort.
- busy  out  1  state ≠ IDLE.
- err_timeout  out  1  sticky: any timeout occurred.
- err_spurious  out  1  sticky: calc_done seen outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- Eligibility: requester i is eligible when req_valid[i] is high and rsp_valid[i] is low.
- IDLE: if any requester is eligible, pick g by rotating priority starting at rr_ptr, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): calc_start=1, req_ack[g]=1, calc_sel=g, rr_ptr←(g+1) mod NUM_REQ, timeout counter←0. Next state is WAIT.
- WAIT: calc_sel held at g. On calc_done:
  - rsp_threshold[g]←calc_threshold, rsp_valid[g]←1, rsp_err[g]←0.
  - Next state is IDLE.
- WAIT timeout: if the counter reaches TIMEOUT_CYC-1 without calc_done:
  - rsp_threshold[g]←0, rsp_valid[g]←1, rsp_err[g]←1, err_timeout←1.
  - Next state is IDLE.
- calc_done with counter == TIMEOUT_CYC-1: done wins; no timeout is flagged.
- calc_done in IDLE or ISSUE sets err_spurious and is otherwise ignored, including a late done after a timeout.
- rsp_ready[i] with rsp_valid[i]=1 clears rsp_valid[i] next edge. rsp_ready on an empty slot is ignored.
- Slot clear and a new grant to the same requester cannot coincide, because a full slot masks eligibility. Clearing slot i in the same cycle as another slot fills is legal and independent.
- Sticky error flags clear only on reset.

## Timing
- All outputs are registered.
- Reset values: state IDLE, rr_ptr 0, calc_start 0, calc_sel 0, req_ack 0, rsp_valid 0, rsp_threshold 0, rsp_err 0, busy 0, err_timeout 0, err_spurious 0.
- Reset mid-transaction returns to IDLE immediately and discards the in-flight grant. The calculator shares the same reset.
- Request latency: eligible sampled at edge t → calc_start/req_ack high during cycle t+1.
- Response latency: calc_done sampled at edge u → rsp_valid high from cycle u+1.
- Back-to-back: the next grant's calc_start can occur at u+2, with a minimum 1 IDLE cycle between transactions.
- Requester obligation: deassert req_valid the cycle after req_ack. A requester holding req_valid high after ack issues a new request once its slot empties.

## Structure
- Package threshold_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the index width function clog2(NUM_REQ);
  - the TIMEOUT counter width constant $clog2(TIMEOUT_CYC).
- Sub-module rr_pick: combinational rotate-priority one-hot picker with inputs eligible[NUM_REQ] and rr_ptr, and outputs grant index and any_valid. It is instantiated once.

## Test plan
- Single request: req_valid[2]=1 at t0 → req_ack[2] and calc_start at t0+1, calc_sel=2. calc_done with calc_threshold=0x2A five cycles later → rsp_valid[2]=1 and rsp_threshold[2]=0x2A next cycle. rsp_ready[2] clears it.
- Fairness: all four requesters held high, each done returned 3 cycles after start, slots drained immediately → grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Masking: rsp_valid[1] full and not consumed, req_valid[1] re-asserted → no grant to 1 until rsp_ready[1], then requester 1 is granted in its rotation turn.
- Timeout: TIMEOUT_CYC=8, no calc_done → rsp_valid[g]=1, rsp_err[g]=1, rsp_threshold[g]=0, err_timeout=1 after 8 WAIT cycles. A late calc_done sets err_spurious with slot unchanged.
- Boundary: calc_done in the final WAIT cycle → normal result, err_timeout stays 0.
- Async reset asserted mid-WAIT → all outputs at reset values within the same cycle. A fresh request after release is granted to requester 0 first.
